// File: rtl/dbf_ch_gen.sv
// Digital-beamforming receive channel: circular coarse-delay buffer, per-zone delay LUT,
// linear-interpolation fine delay, apodisation, then shift and saturate to OUT_WD.
module dbf_ch_gen #(
  parameter int INPUT_WD  = 14,
  parameter int APO_WD    = 16,
  parameter int FRAC_WD   = 4,
  parameter int CD_DEPTH  = 512,
  parameter int CD_WD     = 9,
  parameter int ADDR_WD   = 8,
  parameter int APO_SHIFT = 15,
  parameter int OUT_WD    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_en,
  input  logic                      start,
  input  logic [INPUT_WD-1:0]       ch_in,
  input  logic [APO_WD-1:0]         apo_din,
  input  logic                      zone_step,
  input  logic                      fd_bypass,
  input  logic                      lut_we,
  input  logic [ADDR_WD-1:0]        lut_addr,
  input  logic [CD_WD+FRAC_WD-1:0]  lut_din,
  output logic [OUT_WD-1:0]         dbf_ch_dout,
  output logic                      dbf_ch_dout_valid,
  output logic [INPUT_WD-1:0]       cd_dout,
  output logic                      sat_flag
);

  localparam int STAGES = 4;
  localparam int LUT_WD = CD_WD + FRAC_WD;
  localparam int Y_WD   = INPUT_WD + FRAC_WD + 1;
  localparam int P_WD   = Y_WD + APO_WD;
  localparam int SHIFT  = FRAC_WD + APO_SHIFT;
  localparam int NZONE  = 1 << ADDR_WD;

  localparam logic [CD_WD-1:0]        CD_MAX   = CD_WD'(CD_DEPTH - 2);
  localparam logic [CD_WD:0]          FILL_MAX = (CD_WD+1)'(CD_DEPTH);
  localparam logic signed [P_WD-1:0]  O_MAX    = {{(P_WD-OUT_WD+1){1'b0}}, {(OUT_WD-1){1'b1}}};
  localparam logic signed [P_WD-1:0]  O_MIN    = ~O_MAX;

  // ---------------- control / write side ----------------
  logic                start_d;
  logic [CD_WD-1:0]    wp;
  logic [CD_WD:0]      fill;
  logic [ADDR_WD-1:0]  zidx;

  logic [LUT_WD-1:0]   lut  [NZONE];
  logic [INPUT_WD-1:0] cbuf [CD_DEPTH];

  logic                accept, primed, vld_in;
  logic [LUT_WD-1:0]   lut_q;
  logic [CD_WD-1:0]    cd_raw, cd_eff, rd0, rd1;
  logic [FRAC_WD-1:0]  frac_eff;

  always_comb begin
    accept   = start & ~tx_en;
    lut_q    = lut[zidx];
    cd_raw   = lut_q[LUT_WD-1:FRAC_WD];
    cd_eff   = (cd_raw > CD_MAX) ? CD_MAX : cd_raw;
    frac_eff = fd_bypass ? '0 : lut_q[FRAC_WD-1:0];
    rd0      = wp - cd_eff - CD_WD'(1);
    rd1      = wp - cd_eff - CD_WD'(2);
    // fill counts samples already held, so x1 = in[k-2-cd] exists once fill >= cd+2
    primed   = fill >= ({1'b0, cd_eff} + (CD_WD+1)'(2));
    vld_in   = accept & primed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_d <= 1'b0;
      wp      <= '0;
      fill    <= '0;
      zidx    <= '0;
    end else begin
      start_d <= start;
      if (accept) begin
        wp <= wp + CD_WD'(1);
        if (fill != FILL_MAX) fill <= fill + (CD_WD+1)'(1);
      end
      if (start & ~start_d)
        zidx <= '0;
      else if (start & zone_step & ~&zidx)
        zidx <= zidx + ADDR_WD'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (lut_we) lut[lut_addr] <= lut_din;
  end

  // Read ports live in the pipeline block below; non-blocking write gives read-first,
  // so the x1 read that lands on wp at maximum delay still sees the oldest sample.
  always_ff @(posedge clk) begin
    if (accept) cbuf[wp] <= ch_in;
  end

  // ---------------- datapath pipeline ----------------
  logic [STAGES:1]            vld_pipe;
  logic [INPUT_WD-1:0]        x0_q, x1_q;
  logic [FRAC_WD-1:0]         frac1;
  logic [APO_WD-1:0]          apo1, apo2;
  logic signed [Y_WD-1:0]     y_q;
  logic signed [P_WD-1:0]     p_q;

  logic signed [FRAC_WD+1:0]  w0, w1;
  logic signed [Y_WD+1:0]     x0_e, x1_e, w0_e, w1_e, y_sum;
  logic signed [P_WD-1:0]     y_e, a_e, p_c, o_full;
  logic                       clamp_hi, clamp_lo;
  logic [OUT_WD-1:0]          o_sat;

  always_comb begin
    w0       = $signed((FRAC_WD+2)'(1 << FRAC_WD) - {2'b00, frac1});
    w1       = $signed({2'b00, frac1});
    x0_e     = (Y_WD+2)'($signed(x0_q));
    x1_e     = (Y_WD+2)'($signed(x1_q));
    w0_e     = (Y_WD+2)'(w0);
    w1_e     = (Y_WD+2)'(w1);
    y_sum    = x0_e * w0_e + x1_e * w1_e;
    y_e      = P_WD'(y_q);
    a_e      = P_WD'($signed(apo2));
    p_c      = y_e * a_e;
    o_full   = p_q >>> SHIFT;
    clamp_hi = o_full > O_MAX;
    clamp_lo = o_full < O_MIN;
    o_sat    = clamp_hi ? O_MAX[OUT_WD-1:0] :
               clamp_lo ? O_MIN[OUT_WD-1:0] : o_full[OUT_WD-1:0];
  end

  // Stage registers only load on a live sample, so bubbles and priming leave data untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe    <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      frac1       <= '0;
      apo1        <= '0;
      apo2        <= '0;
      y_q         <= '0;
      p_q         <= '0;
      dbf_ch_dout <= '0;
      sat_flag    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], vld_in};
      if (vld_in) begin
        x0_q  <= cbuf[rd0];
        x1_q  <= cbuf[rd1];
        frac1 <= frac_eff;
        apo1  <= apo_din;
      end
      if (vld_pipe[1]) begin
        y_q  <= y_sum[Y_WD-1:0];
        apo2 <= apo1;
      end
      if (vld_pipe[2]) p_q <= p_c;
      if (vld_pipe[3]) begin
        dbf_ch_dout <= o_sat;
        if (clamp_hi | clamp_lo) sat_flag <= 1'b1;
      end
    end
  end

  assign dbf_ch_dout_valid = vld_pipe[STAGES];
  assign cd_dout           = x0_q;

endmodule

// File: tb/tb_dbf_ch_gen.sv
// Bench for dbf_ch_gen: scenario tasks plus a randomized run, all checked against a
// sample-history model (queue indexed by sample number, plain arithmetic for the math).
module tb_dbf_ch_gen;
  localparam int INPUT_WD = 14, APO_WD = 16, FRAC_WD = 4, CD_DEPTH = 16, CD_WD = 4;
  localparam int ADDR_WD = 8, APO_SHIFT = 15, OUT_WD = 12;
  localparam int OMAX = (1 << (OUT_WD-1)) - 1;
  localparam int OMIN = -(1 << (OUT_WD-1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst = 1'b1, tx_en = 1'b0, start = 1'b0;
  logic [INPUT_WD-1:0]      ch_in = '0;
  logic [APO_WD-1:0]        apo_din = '0;
  logic                     zone_step = 1'b0, fd_bypass = 1'b0, lut_we = 1'b0;
  logic [ADDR_WD-1:0]       lut_addr = '0;
  logic [CD_WD+FRAC_WD-1:0] lut_din = '0;
  logic [OUT_WD-1:0]        dbf_ch_dout;
  logic                     dbf_ch_dout_valid;
  logic [INPUT_WD-1:0]      cd_dout;
  logic                     sat_flag;

  dbf_ch_gen #(
    .INPUT_WD(INPUT_WD), .APO_WD(APO_WD), .FRAC_WD(FRAC_WD), .CD_DEPTH(CD_DEPTH),
    .CD_WD(CD_WD), .ADDR_WD(ADDR_WD), .APO_SHIFT(APO_SHIFT), .OUT_WD(OUT_WD)
  ) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .start(start), .ch_in(ch_in), .apo_din(apo_din),
    .zone_step(zone_step), .fd_bypass(fd_bypass), .lut_we(lut_we), .lut_addr(lut_addr),
    .lut_din(lut_din), .dbf_ch_dout(dbf_ch_dout), .dbf_ch_dout_valid(dbf_ch_dout_valid),
    .cd_dout(cd_dout), .sat_flag(sat_flag)
  );

  int n_tests = 0, n_fail = 0;

  // reference model state
  int  hist[$];
  int  lut_m [1 << ADDR_WD];
  int  zidx_m = 0;
  bit  start_d_m = 0;
  bit  pv_v [4];
  bit  pv_s [4];
  int  pv_d [4];
  int  pv_x [4];
  bit  m_valid = 0, m_sat = 0;
  int  m_dout = 0, m_cd = 0;

  function automatic int dout_i();
    return int'($signed(dbf_ch_dout));
  endfunction

  // advance one clock, updating the model from the inputs seen at that edge
  task automatic cyc();
    bit  nv, ns;
    int  nd, nx, k, cd, f, x1;
    longint y, p, o;
    nv = 0; ns = 0; nd = 0; nx = 0;
    if (!rst && start && !tx_en) begin
      k  = hist.size();
      cd = lut_m[zidx_m] >> FRAC_WD;
      if (cd > CD_DEPTH-2) cd = CD_DEPTH-2;
      f  = fd_bypass ? 0 : (lut_m[zidx_m] & ((1 << FRAC_WD) - 1));
      if (k >= cd + 2) begin
        nx = hist[k-1-cd];
        x1 = hist[k-2-cd];
        y  = longint'(nx) * ((1 << FRAC_WD) - f) + longint'(x1) * f;
        p  = y * longint'($signed(apo_din));
        o  = p >>> (FRAC_WD + APO_SHIFT);
        if (o > OMAX) begin o = OMAX; ns = 1; end
        if (o < OMIN) begin o = OMIN; ns = 1; end
        nv = 1; nd = int'(o);
      end
      hist.push_back(int'($signed(ch_in)));
    end
    @(posedge clk);
    if (lut_we) lut_m[lut_addr] = int'(lut_din);
    if (rst) begin
      hist.delete();
      for (int i = 0; i < 4; i++) begin pv_v[i] = 0; pv_s[i] = 0; pv_d[i] = 0; pv_x[i] = 0; end
      m_valid = 0; m_sat = 0; m_dout = 0; m_cd = 0; zidx_m = 0; start_d_m = 0;
    end else begin
      for (int i = 3; i > 0; i--) begin
        pv_v[i] = pv_v[i-1]; pv_s[i] = pv_s[i-1]; pv_d[i] = pv_d[i-1]; pv_x[i] = pv_x[i-1];
      end
      pv_v[0] = nv; pv_s[0] = ns; pv_d[0] = nd; pv_x[0] = nx;
      if (pv_v[0]) m_cd = pv_x[0];
      m_valid = pv_v[3];
      if (pv_v[3]) begin m_dout = pv_d[3]; if (pv_s[3]) m_sat = 1; end
      if (start && !start_d_m) zidx_m = 0;
      else if (start && zone_step && zidx_m < (1 << ADDR_WD) - 1) zidx_m++;
      start_d_m = start;
    end
    #1;
  endtask

  task automatic do_reset();
    start = 0; tx_en = 0; zone_step = 0; fd_bypass = 0; lut_we = 0;
    rst = 1; cyc(); cyc(); rst = 0;
  endtask

  task automatic lut_write(input int addr, input int cd, input int frac);
    lut_we = 1; lut_addr = ADDR_WD'(addr); lut_din = {CD_WD'(cd), FRAC_WD'(frac)};
    cyc();
    lut_we = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (dbf_ch_dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", dbf_ch_dout_valid); end
    n_tests++; if (dbf_ch_dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %0d want 0", dout_i()); end
    n_tests++; if (cd_dout !== '0) begin n_fail++; $display("FAIL reset_cd_dout: got %0d want 0", cd_dout); end
    n_tests++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %0b want 0", sat_flag); end
  endtask

  task automatic test_ramp();
    int first_s, first_v;
    first_s = -1; first_v = 0;
    do_reset();
    lut_write(0, 5, 0);
    apo_din = 16'd16384; start = 1;
    for (int s = 1; s <= 24; s++) begin
      if (s > 20) start = 0;
      ch_in = INPUT_WD'(2 * s);
      cyc();
      n_tests++;
      if (dbf_ch_dout_valid !== m_valid || dout_i() != m_dout || int'($signed(cd_dout)) != m_cd) begin
        n_fail++;
        $display("FAIL ramp s=%0d: valid=%0b dout=%0d cd=%0d want valid=%0b dout=%0d cd=%0d",
                 s, dbf_ch_dout_valid, dout_i(), $signed(cd_dout), m_valid, m_dout, m_cd);
      end
      if (dbf_ch_dout_valid && first_s < 0) begin first_s = s; first_v = dout_i(); end
    end
    n_tests++; if (first_s != 11 || first_v != 2) begin n_fail++; $display("FAIL ramp_first: at step %0d value %0d want step 11 value 2", first_s, first_v); end
    n_tests++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL ramp_sat: got %0b want 0", sat_flag); end
  endtask

  task automatic test_frac();
    int bad, prev;
    bad = 0; prev = -1;
    do_reset();
    lut_write(0, 0, 8);
    apo_din = 16'd16384;
    for (int s = 0; s < 32; s++) begin
      start = !(s >= 12 && s < 16);
      fd_bypass = (s >= 16);
      ch_in = INPUT_WD'((s % 2) ? 100 : 0);
      cyc();
      n_tests++;
      if (dbf_ch_dout_valid !== m_valid || dout_i() != m_dout) begin
        n_fail++;
        $display("FAIL frac s=%0d: valid=%0b dout=%0d want valid=%0b dout=%0d", s, dbf_ch_dout_valid, dout_i(), m_valid, m_dout);
      end
      if (dbf_ch_dout_valid && s < 19 && dout_i() != 25) bad++;
      if (dbf_ch_dout_valid && s >= 20) begin
        if (!(dout_i() == 0 || dout_i() == 50) || dout_i() == prev) bad++;
        prev = dout_i();
      end
    end
    fd_bypass = 0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL frac_values: %0d off-pattern outputs want 0", bad); end
  endtask

  task automatic test_sat();
    bit seen_min;
    seen_min = 0;
    do_reset();
    lut_write(0, 0, 0);
    apo_din = 16'h8000; start = 1;
    for (int s = 0; s < 16; s++) begin
      if (s >= 12) start = 0;
      ch_in = (s < 6) ? INPUT_WD'(8191) : '0;
      cyc();
      n_tests++;
      if (dbf_ch_dout_valid !== m_valid || dout_i() != m_dout || sat_flag !== m_sat) begin
        n_fail++;
        $display("FAIL sat s=%0d: valid=%0b dout=%0d sat=%0b want valid=%0b dout=%0d sat=%0b",
                 s, dbf_ch_dout_valid, dout_i(), sat_flag, m_valid, m_dout, m_sat);
      end
      if (dbf_ch_dout_valid && dout_i() == -2048) seen_min = 1;
    end
    n_tests++; if (!seen_min) begin n_fail++; $display("FAIL sat_clamp: never saw -2048"); end
    n_tests++; if (dout_i() != 0 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: dout=%0d sat=%0b want 0 and 1", dout_i(), sat_flag); end
  endtask

  task automatic test_zone_step();
    int gaps, v23, v24;
    bit seen;
    gaps = 0; seen = 0; v23 = 0; v24 = 0;
    do_reset();
    lut_write(0, 2, 0);
    lut_write(1, 10, 0);
    apo_din = 16'd16384; start = 1;
    for (int s = 1; s <= 30; s++) begin
      zone_step = (s == 20);
      ch_in = INPUT_WD'(2 * s);
      cyc();
      n_tests++;
      if (dbf_ch_dout_valid !== m_valid || dout_i() != m_dout) begin
        n_fail++;
        $display("FAIL zone s=%0d: valid=%0b dout=%0d want valid=%0b dout=%0d", s, dbf_ch_dout_valid, dout_i(), m_valid, m_dout);
      end
      if (dbf_ch_dout_valid) seen = 1; else if (seen) gaps++;
      if (s == 23) v23 = dout_i();
      if (s == 24) v24 = dout_i();
    end
    zone_step = 0; start = 0;
    n_tests++; if (gaps != 0) begin n_fail++; $display("FAIL zone_gap: %0d invalid cycles want 0", gaps); end
    n_tests++; if (v23 != 17 || v24 != 10) begin n_fail++; $display("FAIL zone_switch: got %0d,%0d want 17,10", v23, v24); end
  endtask

  task automatic test_wrap();
    do_reset();
    lut_write(0, 15, 0);
    apo_din = 16'd16384; start = 1;
    for (int s = 1; s <= 64; s++) begin
      if (s > 60) start = 0;
      ch_in = INPUT_WD'(2 * s);
      cyc();
      n_tests++;
      if (dbf_ch_dout_valid !== m_valid || dout_i() != m_dout) begin
        n_fail++;
        $display("FAIL wrap s=%0d: valid=%0b dout=%0d want valid=%0b dout=%0d", s, dbf_ch_dout_valid, dout_i(), m_valid, m_dout);
      end
    end
    n_tests++; if (dout_i() != 45) begin n_fail++; $display("FAIL wrap_last: got %0d want 45", dout_i()); end
  endtask

  task automatic test_back_to_back();
    int kk, gaps, jumps, prev, first_j;
    bit seen;
    kk = 0; gaps = 0; jumps = 0; prev = 0; seen = 0; first_j = -1;
    do_reset();
    lut_write(0, 2, 0);
    apo_din = 16'd16384; start = 1;
    for (int s = 1; s <= 19; s++) begin
      tx_en = (s >= 9 && s <= 11);
      rst   = (s == 19);
      if (!tx_en && !rst) kk++;
      ch_in = tx_en ? INPUT_WD'(777) : INPUT_WD'(2 * kk);
      cyc();
      n_tests++;
      if (dbf_ch_dout_valid !== m_valid || dout_i() != m_dout) begin
        n_fail++;
        $display("FAIL b2b s=%0d: valid=%0b dout=%0d want valid=%0b dout=%0d", s, dbf_ch_dout_valid, dout_i(), m_valid, m_dout);
      end
      if (s <= 18) begin
        if (dbf_ch_dout_valid) begin
          if (seen && dout_i() != prev + 1) jumps++;
          seen = 1; prev = dout_i();
        end else if (seen) gaps++;
      end
    end
    rst = 0; tx_en = 0;
    n_tests++; if (gaps != 3 || jumps != 0) begin n_fail++; $display("FAIL b2b_gap: gap=%0d jumps=%0d want 3 and 0", gaps, jumps); end
    n_tests++; if (dbf_ch_dout_valid !== 1'b0 || dbf_ch_dout !== '0) begin n_fail++; $display("FAIL b2b_rst: valid=%0b dout=%0d want 0 0", dbf_ch_dout_valid, dout_i()); end
    for (int j = 1; j <= 10; j++) begin
      ch_in = INPUT_WD'(2 * j);
      cyc();
      n_tests++;
      if (dbf_ch_dout_valid !== m_valid || dout_i() != m_dout) begin
        n_fail++;
        $display("FAIL b2b_restart j=%0d: valid=%0b dout=%0d want valid=%0b dout=%0d", j, dbf_ch_dout_valid, dout_i(), m_valid, m_dout);
      end
      if (dbf_ch_dout_valid && first_j < 0) first_j = j;
    end
    start = 0;
    n_tests++; if (first_j != 8) begin n_fail++; $display("FAIL b2b_reprime: first valid at %0d want 8", first_j); end
  endtask

  task automatic test_random();
    do_reset();
    for (int a = 0; a < (1 << ADDR_WD); a++) lut_write(a, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    for (int s = 0; s < 3000; s++) begin
      if ($urandom_range(0, 19) == 0) start = ~start;
      tx_en     = ($urandom_range(0, 7) == 0);
      zone_step = ($urandom_range(0, 9) == 0);
      fd_bypass = ($urandom_range(0, 3) == 0);
      lut_we    = ($urandom_range(0, 15) == 0);
      lut_addr  = ($urandom_range(0, 1) == 0) ? ADDR_WD'(zidx_m) : ADDR_WD'($urandom);
      lut_din   = (CD_WD+FRAC_WD)'($urandom);
      rst       = ($urandom_range(0, 499) == 0);
      case ($urandom_range(0, 5))
        0:       ch_in = INPUT_WD'(-8192);
        1:       ch_in = INPUT_WD'(8191);
        default: ch_in = INPUT_WD'($urandom);
      endcase
      apo_din = ($urandom_range(0, 5) == 0) ? 16'h8000 : APO_WD'($urandom);
      cyc();
      n_tests++;
      if (dbf_ch_dout_valid !== m_valid || dout_i() != m_dout || sat_flag !== m_sat ||
          int'($signed(cd_dout)) != m_cd) begin
        n_fail++;
        $display("FAIL random s=%0d: valid=%0b dout=%0d sat=%0b cd=%0d want valid=%0b dout=%0d sat=%0b cd=%0d",
                 s, dbf_ch_dout_valid, dout_i(), sat_flag, $signed(cd_dout), m_valid, m_dout, m_sat, m_cd);
      end
    end
    rst = 0; lut_we = 0; start = 0; tx_en = 0; zone_step = 0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_frac();
    test_sat();
    test_zone_step();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbf_ch_gen.md
# dbf_ch_gen

Parametrised digital-beamforming receive channel and successor to the fixed per-channel DBF blocks. It combines:
- a circular coarse-delay sample buffer,
- a per-focal-zone delay LUT giving coarse and fractional delay,
- linear-interpolation fine delay,
- apodisation, then rounding-free arithmetic shift and saturation to a programmable output width.

One instance sits between each channel ADC stream and the DBF summation tree.

## Interface
Parameters:
- INPUT_WD, 14, signed input sample width
- APO_WD, 16, signed apodisation weight width (Q1.(APO_WD-1))
- FRAC_WD, 4, fractional-delay bits
- CD_DEPTH, 512, coarse buffer depth (power of 2, ≥16)
- CD_WD, 9, log2(CD_DEPTH)
- ADDR_WD, 8, zone LUT address width (2^ADDR_WD zones)
- APO_SHIFT, 15, right shift applied after apodisation (in addition to FRAC_WD)
- OUT_WD, 16, signed output width

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- tx_en  in  1  transmit active; no samples accepted while high
- start  in  1  receive window; rising edge restarts zone indexing
- ch_in  in  INPUT_WD  signed input sample
- apo_din  in  APO_WD  signed apodisation weight, sampled with the sample
- zone_step  in  1  advance to next focal zone (honoured only while start=1)
- fd_bypass  in  1  force frac=0 (coarse delay only)
- lut_we  in  1  zone LUT write strobe
- lut_addr  in  ADDR_WD  zone LUT write address
- lut_din  in  CD_WD+FRAC_WD  {cd, frac}
- dbf_ch_dout  out  OUT_WD  apodised, delayed sample
- dbf_ch_dout_valid  out  1  output qualifier
- cd_dout  out  INPUT_WD  registered coarse-delayed sample x0 (debug)
- sat_flag  out  1  sticky: saturation has occurred

## Operation
- A sample is accepted when start & ~tx_en.
- On each accepted sample at index k:
  - it is written at wp;
  - wp increments modulo CD_DEPTH;
  - fill (samples already buffered before the current one) increments, saturating at CD_DEPTH.
- Zone index zidx:
  - cleared on a start rising edge;
  - +1 on zone_step while start=1, saturating at 2^ADDR_WD-1.
- Zone LUT:
  - asynchronous read of lut[zidx] gives {cd, frac};
  - cd > CD_DEPTH-2 is clamped to CD_DEPTH-2;
  - frac is forced to 0 when fd_bypass=1.
- Buffer RAM is read-first; x0 = in[k-1-cd], x1 = in[k-2-cd].
  - With cd = CD_DEPTH-2, the x1 read hits wp.
  - Read-first returns the old sample, which is correct.
- Fine delay: y = x0·(2^FRAC_WD − frac) + x1·frac, signed, width INPUT_WD+FRAC_WD+1.
- Apodisation: p = y·apo_din, full width.
- Output: o = p >>> (FRAC_WD+APO_SHIFT), arithmetic shift with truncation.
  - o is saturated to [−2^(OUT_WD−1), 2^(OUT_WD−1)−1].
  - Any clamp sets sat_flag; sat_flag clears only on rst.
- Output valid only when fill ≥ cd+2 at accept time.
  - Priming samples produce no valid and no data change.
- LUT write: takes effect the cycle after lut_we. A write and read of the same address in one cycle returns the old entry.
- LUT contents and buffer RAM are not reset.
  - Stale RAM data is never output, because fill restarts at 0.

## Timing
- Pipeline, 4 cycles; the sample is accepted at cycle n:
  - n+1: x0/x1 registered, cd_dout = x0;
  - n+2: y;
  - n+3: p;
  - n+4: dbf_ch_dout and dbf_ch_dout_valid.
- Throughput: 1 sample/cycle.
- apo_din is sampled at n and carried with the sample.
- Non-accept cycles inject bubbles. valid=0 and dbf_ch_dout holds its last value.
- tx_en high or start low:
  - in-flight samples drain normally;
  - wp and fill hold;
  - a resumed stream continues without index gaps.
- Reset values: dbf_ch_dout=0, dbf_ch_dout_valid=0, cd_dout=0, sat_flag=0, wp=0, fill=0, zidx=0, all pipeline valids 0.
- rst mid-stream: outputs reach reset values the cycle after rst is sampled high. In-flight samples are discarded.
- zone_step and a start rising edge in the same cycle: the clear wins.

## Test plan
- Reset; lut[0]={5,0}; apo=16384; ramp in[k]=2k for k=1..20 → first valid 4 cycles after accepting k=8, with dout=2, then incrementing by 1 per cycle; sat_flag=0.
- lut[0]={0,8}; apo=16384; input alternates 0,100 → every valid dout=25; with fd_bypass=1 → dout alternates 50,0.
- OUT_WD=12; lut[0]={0,0}; ch_in=8191; apo=−32768 → dout=−2048, sat_flag=1 and stays 1 after the input returns to 0 (dout=0).
- lut[0]={2,0}, lut[1]={10,0}; apo=16384; ramp; zone_step after 20 samples → at the first accept after the step, the output switches from in[k−3]/2-scaled to in[k−11] values; no valid glitch.
- CD_DEPTH=16; lut[0]={15,0} (clamped to 14); ramp of 60 samples → outputs equal in[k−15] across multiple wp wrap-arounds.
- Ramp with tx_en high for 3 cycles mid-stream, then rst for 1 cycle → a 3-cycle valid gap with continuous output values, then valid=0 and dout=0 the cycle after rst; after restart, re-priming is required (cd+2 samples) before the next valid.
